// File: rtl/fetch_stage.sv
// Fetch front-end: requests lines from the I-cache, unpacks them into a PC-tagged instruction queue.
// Optional FETCH_PERF_CNT_EN builds saturating miss/queue-stall cycle counters.
module fetch_stage #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       ISA_W      = 32,
  parameter int unsigned       LINE_W     = 128,
  parameter int unsigned       IQ_DEPTH   = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [ADDR_W-1:0]             pc_o,
  output logic                          fetch_req_o,
  input  logic [LINE_W-1:0]             line_i,
  input  logic                          hit_i,
  input  logic                          redirect_i,
  input  logic [ADDR_W-1:0]             redirect_pc_i,
  output logic [ISA_W-1:0]              inst_o,
  output logic [ADDR_W-1:0]             inst_pc_o,
  output logic                          inst_valid_o,
  input  logic                          inst_ready_i,
  output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count_o,
  output logic [31:0]                   miss_cnt_o,
  output logic [31:0]                   full_cnt_o
);

  localparam int unsigned WPL     = LINE_W / ISA_W;
  localparam int unsigned LINE_B  = LINE_W / 8;
  localparam int unsigned OFF_LO  = $clog2(ISA_W / 8);
  localparam int unsigned OFF_W   = $clog2(WPL);
  localparam int unsigned BASE_LO = OFF_LO + OFF_W;
  localparam int unsigned PTR_W   = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W   = $clog2(IQ_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [ISA_W-1:0]  mem_inst_q [IQ_DEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [IQ_DEPTH];

  logic [OFF_W-1:0]  off;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  free_slots;
  logic [ADDR_W-1:0] line_base;
  logic              enq, deq;

  assign off         = pc_q[BASE_LO-1:OFF_LO];
  assign n_words     = CNT_W'(WPL) - CNT_W'(off);
  assign free_slots  = CNT_W'(IQ_DEPTH) - count_q;
  assign fetch_req_o = (free_slots >= n_words);
  assign line_base   = pc_q & ~ADDR_W'(LINE_B - 1);

  assign enq = fetch_req_o && hit_i && !redirect_i;
  assign deq = inst_valid_o && inst_ready_i && !redirect_i;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      pc_d     = redirect_pc_i & ~ADDR_W'(3);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) begin
        pc_d     = line_base + ADDR_W'(LINE_B);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_words);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (enq ? n_words : '0) - (deq ? CNT_W'(1) : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_ADDR;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Each entry works out which line word (if any) lands in it this cycle.
  for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] rel;
    logic [OFF_W-1:0] word_idx;
    logic             wr_en;

    assign rel      = PTR_W'(gi) - wr_ptr_q;
    assign wr_en    = enq && (CNT_W'(rel) < n_words);
    assign word_idx = off + OFF_W'(rel);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_inst_q[gi] <= '0;
        mem_pc_q[gi]   <= '0;
      end else if (wr_en) begin
        mem_inst_q[gi] <= line_i[word_idx*ISA_W +: ISA_W];
        mem_pc_q[gi]   <= line_base | (ADDR_W'(word_idx) << OFF_LO);
      end
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = mem_inst_q[rd_ptr_q];
  assign inst_pc_o    = mem_pc_q[rd_ptr_q];
  assign inst_valid_o = (count_q != '0);
  assign iq_count_o   = count_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] miss_cnt_q, full_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
      full_cnt_q <= '0;
    end else begin
      if (fetch_req_o && !hit_i && !redirect_i && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (!fetch_req_o && !redirect_i && (full_cnt_q != 32'hFFFF_FFFF))
        full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign full_cnt_o = full_cnt_q;
`else
  assign miss_cnt_o = 32'd0;
  assign full_cnt_o = 32'd0;
`endif

  // The request gating must make queue overflow unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(IQ_DEPTH));
  a_enq_fits: assert property (@(posedge clk_i) disable iff (!rst_ni)
    enq |-> (n_words <= free_slots));

endmodule

// File: doc/fetch_stage.md
Name:
fetch_stage

Overview:
- Parametrised fetch front-end: drives the fetch PC to the L1 I-cache and accepts a full cache line on hit.
- Unpacks the line into individual instructions from the PC's word offset to the end of the line, tags each with its PC and buffers them in an internal instruction queue.
- Presents a valid/ready instruction stream to decode.
- Adds redirect/flush, partial-line entry after redirect, back-pressure by free-slot count and an occupancy output.

Parameters:
- ADDR_W, 64, PC/address width in bits.
- ISA_W, 32, instruction width in bits.
- LINE_W, 128, I-cache line width in bits; WPL = LINE_W/ISA_W instructions per line (power of 2, >= 2).
- IQ_DEPTH, 8, queue entries; power of 2, >= WPL.
- RESET_ADDR, 0, PC value after reset; must be ISA_W/8-byte aligned.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pc_o  out  ADDR_W  current fetch PC to I-cache (registered).
- fetch_req_o  out  1  fetch request; high when the queue can absorb the line at pc_o.
- line_i  in  LINE_W  I-cache line for pc_o; word k in bits [k*ISA_W +: ISA_W].
- hit_i  in  1  line_i is valid for pc_o this cycle (combinational cache read).
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  ADDR_W  new fetch PC; low 2 bits ignored (forced to 0).
- inst_o  out  ISA_W  head-of-queue instruction.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- inst_valid_o  out  1  queue non-empty.
- inst_ready_i  in  1  decode accepts the head instruction.
- iq_count_o  out  $clog2(IQ_DEPTH+1)  entries currently queued.
- miss_cnt_o  out  32  cache-miss cycle counter (see Optional Feature).
- full_cnt_o  out  32  queue-stall cycle counter (see Optional Feature).

Behaviour:
- Reset (async, rst_ni low): pc_o=RESET_ADDR; count=0; rd/wr pointers=0; storage=0. Consequently inst_valid_o=0, inst_o=0, inst_pc_o=0, iq_count_o=0, counters=0.
- off = pc_o[$clog2(LINE_W/8)-1 : $clog2(ISA_W/8)]; n = WPL - off (1..WPL).
- fetch_req_o = (IQ_DEPTH - count) >= n. Uses registered count; a same-cycle dequeue does not add space.
- Enqueue when fetch_req_o && hit_i && !redirect_i:
  - Words off..WPL-1 are written in ascending order at wr_ptr, each with PC = line base + k*ISA_W/8.
  - count += n; pc_o <= line base + LINE_W/8. Addition wraps modulo 2^ADDR_W.
- Miss (hit_i=0) or fetch_req_o=0: pc_o holds and nothing is written; line_i is ignored.
- Dequeue when inst_valid_o && inst_ready_i: rd_ptr++ (wraps mod IQ_DEPTH), count -= 1.
- Simultaneous enqueue and dequeue: count += n-1.
- Output timing: inst_o/inst_pc_o are a combinational read of the head entry. An instruction enqueued in cycle t is visible at cycle t+1 at the earliest.
- Pointers wrap modulo IQ_DEPTH; overflow and underflow are impossible by construction. Any such occurrence is an assertion failure.
- Redirect has highest priority. In the redirect cycle: line_i and inst_ready_i are ignored; count, rd_ptr and wr_ptr <= 0; pc_o <= {redirect_pc_i[ADDR_W-1:2], 2'b00}. inst_valid_o=0 the next cycle.
- Redirect to a mid-line PC: the next hit enqueues only words from off onward.
- Reset mid-operation: all state returns immediately to reset values; in-flight line data is dropped.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - miss_cnt_o increments each cycle with fetch_req_o && !hit_i && !redirect_i.
  - full_cnt_o increments each cycle with !fetch_req_o && !redirect_i.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan (defaults, WPL=4, 16-byte lines):
- Reset release, hit_i=1 every cycle, inst_ready_i=0 -> pc_o goes 0x0 -> 0x10 -> 0x20; iq_count_o goes 4 -> 8; then fetch_req_o=0 and pc_o holds at 0x20.
- hit_i=1, inst_ready_i=1 continuously -> inst_valid_o first high one cycle after the first hit. inst_pc_o runs 0x0,0x4,0x8,... with no gaps or duplicates, and inst_o equals the matching line_i words.
- redirect_i=1 with redirect_pc_i=0x1009 -> next cycle pc_o=0x1008, iq_count_o=0. The following hit enqueues 2 instructions (PC 0x1008, 0x100C), then pc_o=0x1010.
- hit_i=0 for 3 cycles with queue holding 2 entries and ready=0 -> pc_o and iq_count_o unchanged. With FETCH_PERF_CNT_EN, miss_cnt_o=3.
- redirect_i, hit_i and inst_ready_i all high with count=5 -> next cycle count=0, pc_o=redirect PC, no instruction accepted or enqueued.
- RESET_ADDR=0xFFFF_FFFF_FFFF_FFF0, one hit -> pc_o=0x0, the 4 queued PCs end at 0xFFFF_FFFF_FFFF_FFFC.
